// File: rtl/debug_mem_bridge_pkg.sv
// Shared opcodes, FSM states and small decode helpers for the debug memory bridge.
package debug_mem_bridge_pkg;

    localparam logic [7:0] OP_WR_INST = 8'h01;
    localparam logic [7:0] OP_WR_DATA = 8'h02;
    localparam logic [7:0] OP_RD_INST = 8'h03;
    localparam logic [7:0] OP_RD_DATA = 8'h04;
    localparam logic [7:0] OP_HALT    = 8'h05;
    localparam logic [7:0] OP_RUN     = 8'h06;

    localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_RWAIT,
        ST_RESP,
        ST_ACK,
        ST_ERR
    } state_t;

    function automatic logic is_mem_op(input logic [7:0] op);
        return (op == OP_WR_INST) || (op == OP_WR_DATA) ||
               (op == OP_RD_INST) || (op == OP_RD_DATA);
    endfunction

    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_WR_INST) || (op == OP_WR_DATA);
    endfunction

    function automatic logic is_inst_op(input logic [7:0] op);
        return (op == OP_WR_INST) || (op == OP_RD_INST);
    endfunction

endpackage

// File: rtl/debug_mem_bridge_if.sv
// Host byte link plus the instruction/data cache debug port pair.
interface debug_mem_bridge_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] inst_a2;
    logic [31:0] inst_wd2;
    logic [3:0]  inst_we2;
    logic [31:0] inst_rd2;
    logic [31:0] data_a2;
    logic [31:0] data_wd2;
    logic [3:0]  data_we2;
    logic [31:0] data_rd2;

    modport master (
        input  rx_data, rx_valid, tx_ready, inst_rd2, data_rd2,
        output rx_ready, tx_data, tx_valid,
        output inst_a2, inst_wd2, inst_we2, data_a2, data_wd2, data_we2
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, inst_rd2, data_rd2,
        input  rx_ready, tx_data, tx_valid,
        input  inst_a2, inst_wd2, inst_we2, data_a2, data_wd2, data_we2
    );

endinterface

// File: rtl/dbg_word_shifter.sv
// 32-bit byte-serial shift register: bytes enter at the top and leave at the bottom, LSB first.
// Latency: word updates on the clock after step/load; done marks the 4th step of a word.
// Backpressure: none internally; the owner only asserts step on a completed handshake.
module dbg_word_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_dat,
    input  logic        step,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [31:0] word_nxt,
    output logic        done
);

    logic [1:0] cnt;

    always_comb begin
        word_nxt = word;
        if (load) begin
            word_nxt = load_dat;
        end else if (step) begin
            word_nxt = {byte_in, word[31:8]};
        end
    end

    assign done = (cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else begin
            word <= word_nxt;
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/debug_mem_bridge.sv
// Host byte-command initiator for the core's inst/data cache debug ports and core reset line.
// Latency: write strobe 1 cycle after last data byte, ACK 1 later; read reply RD_LAT+1 after last addr byte.
// Backpressure: rx_ready only while collecting a frame; response bytes held until tx_ready.
module debug_mem_bridge
    import debug_mem_bridge_pkg::*;
#(
    parameter int         RD_LAT   = 2,
    parameter logic [7:0] ACK_BYTE = DEF_ACK_BYTE,
    parameter logic [7:0] ERR_BYTE = DEF_ERR_BYTE
) (
    input  logic                clk,
    input  logic                rst_n,
    debug_mem_bridge_if.master  bus,
    output logic                cpu_rst
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t      state, state_nxt;
    logic [7:0]  op;
    logic        sel_inst;
    logic        rx_rdy, tx_vld, rx_fire, tx_fire;
    logic        addr_step, dat_step, rsp_load, rsp_step;
    logic [31:0] addr_word, addr_nxt, dat_word, dat_nxt, rsp_word, rsp_nxt;
    logic        addr_done, dat_done, rsp_done;
    logic [LW-1:0] lat_cnt;
    logic [7:0]  tx_byte;
    logic [31:0] inst_a2_q, data_a2_q, inst_wd2_q, data_wd2_q;
    logic        unused_shift;

    assign sel_inst = is_inst_op(op);
    // Ready is gated by reset so the host sees 0 while the bridge is held.
    assign rx_rdy   = rst_n && (state inside {ST_IDLE, ST_ADDR, ST_DATA});
    assign tx_vld   = (state inside {ST_ACK, ST_ERR, ST_RESP});
    assign rx_fire  = bus.rx_valid && rx_rdy;
    assign tx_fire  = tx_vld && bus.tx_ready;

    dbg_word_shifter u_addr (
        .clk(clk), .rst_n(rst_n),
        .load(1'b0), .load_dat(32'h0), .step(addr_step), .byte_in(bus.rx_data),
        .word(addr_word), .word_nxt(addr_nxt), .done(addr_done)
    );

    dbg_word_shifter u_wdat (
        .clk(clk), .rst_n(rst_n),
        .load(1'b0), .load_dat(32'h0), .step(dat_step), .byte_in(bus.rx_data),
        .word(dat_word), .word_nxt(dat_nxt), .done(dat_done)
    );

    dbg_word_shifter u_rsp (
        .clk(clk), .rst_n(rst_n),
        .load(rsp_load), .load_dat(sel_inst ? bus.inst_rd2 : bus.data_rd2),
        .step(rsp_step), .byte_in(8'h00),
        .word(rsp_word), .word_nxt(rsp_nxt), .done(rsp_done)
    );

    assign unused_shift = ^{addr_word, dat_word, rsp_nxt, rsp_word[31:8]};

    always_comb begin
        state_nxt = state;
        addr_step = 1'b0;
        dat_step  = 1'b0;
        rsp_load  = 1'b0;
        rsp_step  = 1'b0;
        tx_byte   = 8'h00;
        case (state)
            ST_IDLE: begin
                if (rx_fire) begin
                    if (is_mem_op(bus.rx_data)) begin
                        state_nxt = ST_ADDR;
                    end else if (bus.rx_data == OP_HALT || bus.rx_data == OP_RUN) begin
                        state_nxt = ST_ACK;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ADDR: begin
                addr_step = rx_fire;
                if (rx_fire && addr_done) begin
                    state_nxt = is_write_op(op) ? ST_DATA : ST_RWAIT;
                end
            end
            ST_DATA: begin
                dat_step = rx_fire;
                if (rx_fire && dat_done) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: state_nxt = ST_ACK;
            ST_RWAIT: begin
                // Last wait cycle: the cache read port has settled, capture it.
                if (lat_cnt == LW'(RD_LAT - 1)) begin
                    rsp_load  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                tx_byte  = rsp_word[7:0];
                rsp_step = tx_fire;
                if (tx_fire && rsp_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                tx_byte = ACK_BYTE;
                if (tx_fire) state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                tx_byte = ERR_BYTE;
                if (tx_fire) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op         <= 8'h00;
            cpu_rst    <= 1'b1;
            lat_cnt    <= '0;
            inst_a2_q  <= '0;
            data_a2_q  <= '0;
            inst_wd2_q <= '0;
            data_wd2_q <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= (state == ST_RWAIT) ? lat_cnt + 1'b1 : '0;
            if (state == ST_IDLE && rx_fire) begin
                op <= bus.rx_data;
                if (bus.rx_data == OP_HALT) begin
                    cpu_rst <= 1'b1;
                end else if (bus.rx_data == OP_RUN) begin
                    cpu_rst <= 1'b0;
                end
            end
            // Address/data land in the selected cache's holding register as the word completes.
            if (state == ST_ADDR && rx_fire && addr_done) begin
                if (sel_inst) inst_a2_q <= addr_nxt;
                else          data_a2_q <= addr_nxt;
            end
            if (state == ST_DATA && rx_fire && dat_done) begin
                if (sel_inst) inst_wd2_q <= dat_nxt;
                else          data_wd2_q <= dat_nxt;
            end
        end
    end

    assign bus.rx_ready = rx_rdy;
    assign bus.tx_valid = tx_vld;
    assign bus.tx_data  = tx_byte;
    assign bus.inst_a2  = inst_a2_q;
    assign bus.data_a2  = data_a2_q;
    assign bus.inst_wd2 = inst_wd2_q;
    assign bus.data_wd2 = data_wd2_q;
    assign bus.inst_we2 = (state == ST_WRITE &&  sel_inst) ? 4'hF : 4'h0;
    assign bus.data_we2 = (state == ST_WRITE && !sel_inst) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_debug_mem_bridge.sv
// Bench for debug_mem_bridge: directed protocol steps followed by random command frames vs a memory model.
module tb_debug_mem_bridge;
    import debug_mem_bridge_pkg::*;

    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   hs_cyc = 0;

    debug_mem_bridge_if bus();

    debug_mem_bridge #(.RD_LAT(RD_LAT), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master), .cpu_rst(cpu_rst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fill(input logic [31:0] a, input bit inst);
        return (a * 32'h9E37_79B1) ^ (inst ? 32'h0F0F_0F0F : 32'h0);
    endfunction

    // Cache models: synchronous read port, full-word write on we2.
    logic [31:0] imem [logic [31:0]];
    logic [31:0] dmem [logic [31:0]];
    always @(posedge clk) begin
        if (bus.inst_we2 == 4'hF) imem[bus.inst_a2] = bus.inst_wd2;
        if (bus.data_we2 == 4'hF) dmem[bus.data_a2] = bus.data_wd2;
        bus.inst_rd2 <= imem.exists(bus.inst_a2) ? imem[bus.inst_a2] : fill(bus.inst_a2, 1'b1);
        bus.data_rd2 <= dmem.exists(bus.data_a2) ? dmem[bus.data_a2] : fill(bus.data_a2, 1'b0);
    end

    typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] we; int c; } wr_ev_t;
    wr_ev_t ev_i[$];
    wr_ev_t ev_d[$];
    always @(negedge clk) begin
        if (bus.inst_we2 != 4'h0) ev_i.push_back('{bus.inst_a2, bus.inst_wd2, bus.inst_we2, cyc});
        if (bus.data_we2 != 4'h0) ev_d.push_back('{bus.data_a2, bus.data_wd2, bus.data_we2, cyc});
    end

    // Reference model: what the host expects memory and the core reset to hold.
    logic [31:0] ref_i [logic [31:0]];
    logic [31:0] ref_d [logic [31:0]];
    logic        exp_cpu_rst;

    function automatic logic [31:0] expect_rd(input logic [31:0] a, input bit inst);
        if (inst) return ref_i.exists(a) ? ref_i[a] : fill(a, 1'b1);
        return ref_d.exists(a) ? ref_d[a] : fill(a, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bound(input int n, input string tag);
        checks++;
        assert (n < 200) else begin
            failures++;
            $error("FAIL %s observed=no_handshake expected=handshake_within_200", tag);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "bench stopped: handshake wait expired");
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bound(n, "rx_wait");
        hs_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a,
                              input logic [31:0] d, input int gap_max);
        send_byte(op);
        if (is_mem_op(op)) begin
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
                send_byte(a[8*i +: 8]);
            end
        end
        if (is_write_op(op)) begin
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
                send_byte(d[8*i +: 8]);
            end
        end
    endtask

    task automatic wait_tx(output int vc);
        int n = 0;
        while (bus.tx_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bound(n, "tx_wait");
        vc = cyc;
    endtask

    task automatic recv_byte(output logic [7:0] b, output int vc, input int delay);
        wait_tx(vc);
        repeat (delay) @(negedge clk);
        b = bus.tx_data;
        bus.tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.tx_ready = 1'b0;
    endtask

    task automatic recv_word(output logic [31:0] w, output int vc0, output int vc3, input int dmax);
        logic [7:0] b;
        int vc;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b, vc, $urandom_range(0, dmax));
            w[8*i +: 8] = b;
            if (i == 0) vc0 = vc;
            vc3 = vc;
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        logic [31:0] pool [6];
        int          vc, vc0, vc3, h;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        imem[32'h4] = 32'h0050_0093;
        ref_i[32'h4] = 32'h0050_0093;
        exp_cpu_rst = 1'b1;

        // Reset values while held.
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", bus.rx_ready, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_inst_a2", bus.inst_a2, 0);
        chk("rst_data_a2", bus.data_a2, 0);
        chk("rst_inst_wd2", bus.inst_wd2, 0);
        chk("rst_data_wd2", bus.data_wd2, 0);
        chk("rst_we2", {bus.inst_we2, bus.data_we2}, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        rst_n = 1'b1;
        #1 chk("idle_rx_ready", bus.rx_ready, 1);
        @(negedge clk);

        // Write data word.
        ev_i.delete(); ev_d.delete();
        send_frame(OP_WR_DATA, 32'h10, 32'hDEAD_BEEF, 0);
        h = hs_cyc;
        recv_byte(b, vc, 0);
        chk("wd_ack", b, 8'hA5);
        chk("wd_ack_lat", vc - h, 2);
        chk("wd_ev_cnt", ev_d.size(), 1);
        if (ev_d.size() > 0) begin
            chk("wd_we", ev_d[0].we, 4'hF);
            chk("wd_a2", ev_d[0].a, 32'h10);
            chk("wd_wd2", ev_d[0].d, 32'hDEAD_BEEF);
            chk("wd_we_lat", ev_d[0].c - h, 1);
        end
        chk("wd_inst_ev", ev_i.size(), 0);
        chk("wd_tx_idle", bus.tx_valid, 0);
        ref_d[32'h10] = 32'hDEAD_BEEF;

        // Read instruction word at 4.
        send_frame(OP_RD_INST, 32'h4, 32'h0, 0);
        h = hs_cyc;
        recv_word(w, vc0, vc3, 0);
        chk("ri_word", w, 32'h0050_0093);
        chk("ri_first_lat", vc0 - h, RD_LAT + 1);
        chk("ri_no_gap", vc3 - vc0, 3);

        // Run then halt.
        send_byte(OP_RUN);
        chk("run_cpu_rst", cpu_rst, 0);
        recv_byte(b, vc, 0);
        chk("run_ack", b, 8'hA5);
        send_byte(OP_HALT);
        chk("halt_cpu_rst", cpu_rst, 1);
        recv_byte(b, vc, 0);
        chk("halt_ack", b, 8'hA5);

        // Unknown opcode.
        ev_i.delete(); ev_d.delete();
        send_byte(8'h7F);
        recv_byte(b, vc, 0);
        chk("bad_err", b, 8'hEE);
        chk("bad_no_we", ev_i.size() + ev_d.size(), 0);

        // Response held under tx backpressure; new command bytes refused.
        send_frame(OP_RD_DATA, 32'h10, 32'h0, 0);
        wait_tx(vc);
        b = bus.tx_data;
        bus.rx_data  = OP_RUN;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_tx_valid", bus.tx_valid, 1);
            chk("bp_tx_data", bus.tx_data, b);
            chk("bp_rx_ready", bus.rx_ready, 0);
        end
        bus.rx_valid = 1'b0;
        recv_word(w, vc0, vc3, 0);
        chk("bp_word", w, 32'hDEAD_BEEF);
        chk("bp_cpu_rst", cpu_rst, 1);

        // Reset in the middle of an address phase.
        send_byte(OP_RUN);
        recv_byte(b, vc, 0);
        send_byte(OP_WR_INST);
        send_byte(8'h44);
        send_byte(8'h33);
        rst_n = 1'b0;
        #1;
        chk("mid_rx_ready", bus.rx_ready, 0);
        chk("mid_tx_valid", bus.tx_valid, 0);
        chk("mid_a2", {bus.inst_a2, bus.data_a2}, 0);
        chk("mid_wd2", {bus.inst_wd2, bus.data_wd2}, 0);
        chk("mid_we2", {bus.inst_we2, bus.data_we2}, 0);
        chk("mid_cpu_rst", cpu_rst, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ev_i.delete(); ev_d.delete();
        send_frame(OP_WR_INST, 32'h100, 32'h1234_5678, 0);
        recv_byte(b, vc, 0);
        chk("post_ack", b, 8'hA5);
        chk("post_ev_cnt", ev_i.size(), 1);
        if (ev_i.size() > 0) chk("post_wd2", ev_i[0].d, 32'h1234_5678);
        ref_i[32'h100] = 32'h1234_5678;
        send_frame(OP_RD_INST, 32'h100, 32'h0, 0);
        recv_word(w, vc0, vc3, 0);
        chk("post_rd", w, 32'h1234_5678);

        // Random command frames against the reference model.
        exp_cpu_rst = 1'b1;
        foreach (pool[i]) pool[i] = $urandom;
        for (int t = 0; t < 40; t++) begin
            int          sel;
            logic [7:0]  op;
            logic [31:0] a, d;
            sel = $urandom_range(0, 9);
            a   = pool[$urandom_range(0, 5)];
            d   = $urandom;
            ev_i.delete(); ev_d.delete();
            if (sel < 8) begin
                op = OP_WR_INST + 8'(sel / 2);
                send_frame(op, a, d, 2);
                if (is_write_op(op)) begin
                    recv_byte(b, vc, $urandom_range(0, 3));
                    chk("rnd_wr_ack", b, 8'hA5);
                    if (is_inst_op(op)) begin
                        ref_i[a] = d;
                        chk("rnd_wr_cnt", {ev_i.size(), ev_d.size()}, {32'd1, 32'd0});
                        if (ev_i.size() > 0) chk("rnd_wr_a2", ev_i[0].a, a);
                        if (ev_i.size() > 0) chk("rnd_wr_wd2", ev_i[0].d, d);
                    end else begin
                        ref_d[a] = d;
                        chk("rnd_wr_cnt", {ev_i.size(), ev_d.size()}, {32'd0, 32'd1});
                        if (ev_d.size() > 0) chk("rnd_wr_a2", ev_d[0].a, a);
                        if (ev_d.size() > 0) chk("rnd_wr_wd2", ev_d[0].d, d);
                    end
                end else begin
                    recv_word(w, vc0, vc3, 3);
                    chk("rnd_rd_word", w, expect_rd(a, is_inst_op(op)));
                    chk("rnd_rd_no_we", ev_i.size() + ev_d.size(), 0);
                end
            end else if (sel == 8) begin
                op = ($urandom_range(0, 1) == 1) ? OP_HALT : OP_RUN;
                exp_cpu_rst = (op == OP_HALT);
                send_byte(op);
                recv_byte(b, vc, $urandom_range(0, 3));
                chk("rnd_ctl_ack", b, 8'hA5);
                chk("rnd_cpu_rst", cpu_rst, exp_cpu_rst);
            end else begin
                op = 8'($urandom_range(7, 255));
                send_byte(op);
                recv_byte(b, vc, $urandom_range(0, 3));
                chk("rnd_bad_err", b, 8'hEE);
                chk("rnd_bad_no_we", ev_i.size() + ev_d.size(), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_mem_bridge.md
# debug_mem_bridge

Debug-port initiator for the RV32I core: consumes a byte-stream command protocol from a host link (UART or JTAG byte FIFO) and drives the core's instruction-cache and data-cache debug ports (address, write data, byte write enables, read data) to load programs and dump memory. It also owns the core's reset line so the host can halt the CPU, load memory, and release it. It sits beside the core at top level and is the only driver of the debug port pair.

## Interface
Parameters:
- RD_LAT, 2, cycles from debug address applied to read-data sample (covers synchronous cache read port)
- ACK_BYTE, 8'hA5, response byte for successful write/control commands
- ERR_BYTE, 8'hEE, response byte for unknown opcode

Ports:
- clk  in  1  core clock; everything here is single-clock
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  command byte from host link
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data this cycle
- tx_data  out  8  response byte to host link
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host link accepts tx_data this cycle
- inst_a2 / data_a2  out  32  debug address to instruction / data cache
- inst_wd2 / data_wd2  out  32  debug write data
- inst_we2 / data_we2  out  4  debug byte write enables
- inst_rd2 / data_rd2  in  32  debug read data
- cpu_rst  out  1  active-high reset to core; 1 = CPU held

## Operation
- Frame: opcode byte, then 4 address bytes LSB first, then (writes only) 4 data bytes LSB first. Opcodes: 8'h01 write inst, 8'h02 write data, 8'h03 read inst, 8'h04 read data, 8'h05 halt (cpu_rst=1), 8'h06 run (cpu_rst=0). Halt/run carry no address bytes.
- States: IDLE -> ADDR (4 bytes) -> {DATA (4 bytes) -> WRITE -> ACK | RWAIT -> RESP}; IDLE -> ACK on 05/06; IDLE -> ERR on any other opcode; ACK/ERR/RESP return to IDLE once last byte accepted.
- WRITE: one cycle, selected cache's we2 = 4'hF with a2/wd2 = assembled word; the other cache's we2 stays 0. Full-word writes only.
- RWAIT: a2 held for RD_LAT cycles; selected rd2 captured on last RWAIT cycle into response register.
- RESP: 4 bytes sent LSB first. ACK/ERR: single byte.
- Address bits [1:0] passed through unmodified; word alignment is the cache's concern.
- a2 outputs hold last value outside transactions; wd2 holds; we2 is 0 except in WRITE.
- No command is accepted while any response is pending (no pipelining of frames).

## Timing
- Reset (async assert, sync-released by the system): state IDLE, rx_ready 0 in reset then 1 in IDLE, tx_valid 0, tx_data 0, all a2/wd2 0, we2 0, cpu_rst 1.
- rx_ready = 1 only in IDLE, ADDR, DATA; byte consumed on rx_valid && rx_ready.
- tx_valid asserted the cycle after entering ACK/ERR/RESP; tx_data stable while tx_valid && !tx_ready; next byte presented the cycle after the handshake, no gap required.
- Write latency: WRITE occurs the cycle after the 4th data byte handshake; ACK tx_valid one cycle later.
- Read latency: RESP first byte valid RD_LAT+1 cycles after the 4th address byte handshake.
- cpu_rst changes the cycle after the 05/06 opcode handshake; ACK follows.
- Reset mid-frame: partial frame discarded, any in-flight we2 cleared immediately; cpu_rst returns to 1.
- Host stalls (rx_valid low mid-frame, tx_ready low) are indefinite; no timeout.

## Structure
- Package debug_mem_bridge_pkg: opcode constants, state enum, default ACK/ERR byte values.
- Sub-module dbg_word_shifter: 32-bit byte-serial shift register (load byte LSB-first, shift out byte LSB-first, 2-bit byte counter with done flag); instantiated for address, write data, and read response.

## Test plan
- Write data: 02, 10 00 00 00, EF BE AD DE -> single cycle data_we2=4'hF, data_a2=32'h10, data_wd2=32'hDEADBEEF; tx one byte A5; inst_we2 stays 0.
- Read inst with inst_rd2 model of RD_LAT=2 returning 32'h00500093 at addr 32'h4: 03, 04 00 00 00 -> tx bytes 93 00 50 00 in order, first valid 3 cycles after last addr byte.
- Halt/run: after reset cpu_rst=1; send 06 -> cpu_rst=0 then tx A5; send 05 -> cpu_rst=1, tx A5.
- Bad opcode 7F -> tx EE, no we2 activity, next valid frame processes normally.
- Backpressure: tx_ready held 0 for 10 cycles during RESP -> tx_data/tx_valid stable, rx_ready 0, no bytes lost.
- rst_n pulsed low after 2 address bytes -> outputs return to reset values same cycle; subsequent full frame executes correctly.
